// File: rtl/reg_file_8x32_pkg.sv
// Shared constants for the 8-entry register file: default widths,
// entry count and the value every entry takes on reset.
`timescale 1ns/1ps
package reg_file_8x32_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 3;
    localparam int NUM_REGS   = 1 << DEF_ADDR_W;

    localparam logic [DEF_DATA_W-1:0] RESET_VAL = 32'h0000_0000;

endpackage : reg_file_8x32_pkg

// File: rtl/reg_file_8x32_if.sv
// Write/read bus of the register file. The master side owns the write
// port and the read address; the slave side returns the read data.
`timescale 1ns/1ps
interface reg_file_8x32_if
    import reg_file_8x32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;

    modport master (
        output we,
        output wAddr,
        output wData,
        output rAddr,
        input  rData
    );

    modport slave (
        input  we,
        input  wAddr,
        input  wData,
        input  rAddr,
        output rData
    );

endinterface : reg_file_8x32_if

// File: rtl/reg_file_8x32_reg32_en.sv
// One DATA_W-bit storage register with a load enable. Cleared
// asynchronously by reset_n, which takes priority over a load.
`timescale 1ns/1ps
module reg32_en
    import reg_file_8x32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Hold the stored word; capture d on a clock edge when load is set.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // its inputs before any of them update, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= DATA_W'(RESET_VAL);
        end else if (load) begin
            q <= d;
        end
    end

endmodule : reg32_en

// File: rtl/reg_file_8x32.sv
// Eight-entry register file: one synchronous write port gated by we and
// one purely combinational read port with no write-to-read bypass.
`timescale 1ns/1ps
module reg_file_8x32
    import reg_file_8x32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    reg_file_8x32_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  load_en;
    logic [DATA_W-1:0] entries [DEPTH];

    // Decode the write address into one-hot load enables, gated by we.
    // NOTE: load_en gets a full default before the conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_en = '0;
        if (bus.we) begin
            load_en[bus.wAddr] = 1'b1;
        end
    end

    // NOTE: the storage is built from individually reset flops rather than
    // a RAM macro, because every entry must read zero straight after reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        reg32_en #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load_en[i]),
            .d       (bus.wData),
            .q       (entries[i])
        );
    end

    // Read mux: rData follows rAddr within the same cycle; an entry being
    // written shows its old value until the clock edge.
    always_comb begin
        bus.rData = entries[bus.rAddr];
    end

endmodule : reg_file_8x32

// File: tb/tb_reg_file_8x32.sv
// Bench for reg_file_8x32: directed scenarios followed by randomized
// traffic, all compared against a plain array model of the eight entries.
`timescale 1ns/1ps
module tb_reg_file_8x32;
    import reg_file_8x32_pkg::*;

    logic clk;
    logic reset_n;

    reg_file_8x32_if bus ();

    reg_file_8x32 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference contents of the register file.
    logic [31:0] model [NUM_REGS];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    endtask

    // Read one address after a short settle and compare to the model.
    task automatic read_check(input string tag, input int addr);
        bus.rAddr = 3'(addr);
        #0.5;
        check($sformatf("%s[%0d]", tag, addr), bus.rData, model[addr]);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NUM_REGS; i++) read_check(tag, i);
    endtask

    // Drive a write at the falling edge, let the rising edge take it,
    // then drop we so later reads can span edges safely.
    task automatic do_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.wAddr = 3'(addr);
        bus.wData = data;
        @(posedge clk);
        model[addr] = data;
        #1;
        bus.we = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd_data;
        int          rnd_waddr;
        int          rnd_raddr;
        logic        rnd_we;

        // Reset held from time zero: every entry reads zero.
        reset_n   = 1'b0;
        bus.we    = 1'b0;
        bus.wAddr = '0;
        bus.wData = '0;
        bus.rAddr = '0;
        model_clear();
        read_all("reset");

        // A write attempted on an edge while reset is held must not land.
        bus.we    = 1'b1;
        bus.wAddr = 3'd3;
        bus.wData = 32'hFFFF_9999;
        @(posedge clk);
        #0.5;
        bus.rAddr = 3'd3;
        #0.25;
        check("reset_blocks_write", bus.rData, 32'h0);
        bus.we = 1'b0;

        // Release reset between edges (7 ns).
        #(7.0 - $realtime);
        reset_n = 1'b1;

        // Sequential writes, including held data to a new address.
        do_write(0, 32'h1111_0000);
        do_write(1, 32'hABCD_1234);
        do_write(2, 32'hABCD_1234);
        do_write(3, 32'hFFFF_9999);
        check("seq_r0", model[0], 32'h1111_0000);
        read_all("seq");

        // we=0 leaves entries unchanged over several edges.
        @(negedge clk);
        bus.we    = 1'b0;
        bus.wAddr = 3'd1;
        bus.wData = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        bus.rAddr = 3'd1;
        #0.5;
        check("we_gate", bus.rData, 32'hABCD_1234);

        // No bypass: old value before the edge, new value right after.
        @(negedge clk);
        bus.rAddr = 3'd5;
        bus.we    = 1'b1;
        bus.wAddr = 3'd5;
        bus.wData = 32'h5555_AAAA;
        #1;
        check("no_bypass_before", bus.rData, 32'h0);
        @(posedge clk);
        #1;
        check("no_bypass_after", bus.rData, 32'h5555_AAAA);
        model[5] = 32'h5555_AAAA;
        bus.we = 1'b0;
        // rAddr change between edges shows up in the same cycle.
        bus.rAddr = 3'd1;
        #0.5;
        check("raddr_comb", bus.rData, 32'hABCD_1234);

        // Asynchronous reset pulse between edges clears everything at once.
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        model_clear();
        #0.25;
        check("async_rst_r1", bus.rData, 32'h0);
        read_all("async_rst");
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Exhaustive pattern: entry i gets 0x0101_0101 * i.
        for (int i = 0; i < NUM_REGS; i++) do_write(i, 32'h0101_0101 * i);
        check("exh_r7", model[7], 32'h0707_0707);
        read_all("exh");

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rnd_we    = ($urandom_range(0, 3) != 0);
            rnd_waddr = $urandom_range(0, NUM_REGS - 1);
            rnd_raddr = $urandom_range(0, NUM_REGS - 1);
            rnd_data  = $urandom;
            bus.we    = rnd_we;
            bus.wAddr = 3'(rnd_waddr);
            bus.wData = rnd_data;
            bus.rAddr = 3'(rnd_raddr);
            #1;
            check("rnd_pre", bus.rData, model[rnd_raddr]);
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                model_clear();
                #1;
                check("rnd_rst", bus.rData, 32'h0);
                reset_n = 1'b1;
                bus.we  = 1'b0;
                rnd_we  = 1'b0;
            end
            @(posedge clk);
            if (rnd_we) model[rnd_waddr] = rnd_data;
            #1;
            check("rnd_post", bus.rData, model[rnd_raddr]);
            rnd_raddr = $urandom_range(0, NUM_REGS - 1);
            bus.rAddr = 3'(rnd_raddr);
            #0.5;
            check("rnd_any", bus.rData, model[rnd_raddr]);
        end

        bus.we = 1'b0;
        read_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_8x32
